// File: rtl/dead_time_pkg.sv
// rtl/dead_time_pkg.sv - shared leg state/command encodings and dead-time defaults
package dead_time_pkg;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_HI  = 2'd1,
    ST_LO  = 2'd2,
    ST_DT  = 2'd3
  } leg_state_t;

  typedef enum logic [1:0] {
    CMD_OFF = 2'd0,
    CMD_HI  = 2'd1,
    CMD_LO  = 2'd2,
    CMD_INV = 2'd3
  } leg_cmd_t;

  localparam int DT_MIN_DEFAULT = 2;

  function automatic leg_cmd_t decode_cmd(input logic hi, input logic lo);
    case ({hi, lo})
      2'b10:   return CMD_HI;
      2'b01:   return CMD_LO;
      2'b11:   return CMD_INV;
      default: return CMD_OFF;
    endcase
  endfunction

endpackage

// File: rtl/dead_time_leg.sv
// rtl/dead_time_leg.sv - one bridge leg: command decode, dead-time FSM, counter, gate registers
module dead_time_leg
  import dead_time_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DT_MIN = DT_MIN_DEFAULT
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             force_off,
  input  logic             hi_cmd,
  input  logic             lo_cmd,
  input  logic [CNT_W-1:0] deadtime,
  output logic             hi_gate,
  output logic             lo_gate,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DT_MIN_C = CNT_W'(DT_MIN);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  leg_state_t       state;
  leg_cmd_t         cmd;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  assign cmd      = decode_cmd(hi_cmd, lo_cmd);
  assign load_val = (deadtime < DT_MIN_C) ? DT_MIN_C : deadtime;

  // Gates are only ever raised on the DT expiry edge, so no path can skip the dead time.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      cnt     <= '0;
      hi_gate <= 1'b0;
      lo_gate <= 1'b0;
      busy    <= 1'b0;
    end else if (force_off) begin
      state   <= ST_OFF;
      cnt     <= '0;
      hi_gate <= 1'b0;
      lo_gate <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_OFF: if (cmd == CMD_HI || cmd == CMD_LO) begin
          state <= ST_DT;
          cnt   <= load_val;
          busy  <= 1'b1;
        end
        ST_HI: if (cmd != CMD_HI) begin
          state   <= ST_DT;
          cnt     <= load_val;
          hi_gate <= 1'b0;
          busy    <= 1'b1;
        end
        ST_LO: if (cmd != CMD_LO) begin
          state   <= ST_DT;
          cnt     <= load_val;
          lo_gate <= 1'b0;
          busy    <= 1'b1;
        end
        ST_DT: if (cnt == ONE_C) begin
          busy <= 1'b0;
          cnt  <= '0;
          if (cmd == CMD_HI) begin
            state   <= ST_HI;
            hi_gate <= 1'b1;
          end else if (cmd == CMD_LO) begin
            state   <= ST_LO;
            lo_gate <= 1'b1;
          end else begin
            state <= ST_OFF;
          end
        end else begin
          cnt <= cnt - ONE_C;
        end
        default: state <= ST_OFF;
      endcase
    end
  end

endmodule

// File: rtl/dead_time_gen.sv
// rtl/dead_time_gen.sv - full-bridge dead-time generator (two legs)
// Optional sticky invalid-command fault: DEAD_TIME_FAULT_EN
module dead_time_gen
  import dead_time_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DT_MIN = DT_MIN_DEFAULT
) (
  input  logic             i_clock,
  input  logic             i_RESET,
  input  logic             i_enable,
  input  logic [3:0]       i_MOSFET,
  input  logic [CNT_W-1:0] i_deadtime,
  output logic [3:0]       o_MOSFET,
  output logic [1:0]       o_busy,
  output logic             o_fault
);

  logic force_off;

`ifdef DEAD_TIME_FAULT_EN
  logic fault;
  logic inv_seen;

  assign inv_seen = i_enable & ((i_MOSFET[0] & i_MOSFET[2]) | (i_MOSFET[1] & i_MOSFET[3]));

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) fault <= 1'b0;
    else          fault <= fault | inv_seen;
  end

  // Including inv_seen drops the legs on the same edge the fault is latched.
  assign force_off = ~i_enable | fault | inv_seen;
  assign o_fault   = fault;
`else
  assign force_off = ~i_enable;
  assign o_fault   = 1'b0;
`endif

  dead_time_leg #(.CNT_W(CNT_W), .DT_MIN(DT_MIN)) u_leg_a (
    .clock     (i_clock),
    .rst_n     (i_RESET),
    .force_off (force_off),
    .hi_cmd    (i_MOSFET[0]),
    .lo_cmd    (i_MOSFET[2]),
    .deadtime  (i_deadtime),
    .hi_gate   (o_MOSFET[0]),
    .lo_gate   (o_MOSFET[2]),
    .busy      (o_busy[0])
  );

  dead_time_leg #(.CNT_W(CNT_W), .DT_MIN(DT_MIN)) u_leg_b (
    .clock     (i_clock),
    .rst_n     (i_RESET),
    .force_off (force_off),
    .hi_cmd    (i_MOSFET[1]),
    .lo_cmd    (i_MOSFET[3]),
    .deadtime  (i_deadtime),
    .hi_gate   (o_MOSFET[1]),
    .lo_gate   (o_MOSFET[3]),
    .busy      (o_busy[1])
  );

endmodule

// File: tb/tb_dead_time_gen.sv
// tb/tb_dead_time_gen.sv - scoreboard bench for dead_time_gen with directed vectors
module tb_dead_time_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] mos = 4'b0000;
  logic [7:0] dt = 8'd0;
  logic [3:0] o_mos;
  logic [1:0] o_busy;
  logic       o_fault;

  typedef struct {
    int         due;
    logic [3:0] mos;
    logic [1:0] busy;
    logic       flt;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   run_inv = 1'b0;

`ifdef DEAD_TIME_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  dead_time_gen #(.CNT_W(8), .DT_MIN(2)) dut (
    .i_clock    (clk),
    .i_RESET    (rst_n),
    .i_enable   (en),
    .i_MOSFET   (mos),
    .i_deadtime (dt),
    .o_MOSFET   (o_mos),
    .o_busy     (o_busy),
    .o_fault    (o_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation that has come due and checks the leg invariant.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({o_mos, o_busy, o_fault} !== {e.mos, e.busy, e.flt}) begin
        n_err++;
        $display("FAIL %s cyc=%0d: got mos=%b busy=%b fault=%b, want mos=%b busy=%b fault=%b",
                 e.name, cyc, o_mos, o_busy, o_fault, e.mos, e.busy, e.flt);
      end
    end
    if (run_inv) begin
      n_cmp++;
      if ((o_mos[0] & o_mos[2]) | (o_mos[1] & o_mos[3])) begin
        n_err++;
        $display("FAIL shoot_through cyc=%0d: got mos=%b, want no leg with both gates on", cyc, o_mos);
      end
    end
  end

  task automatic step(input logic e_n, input logic [3:0] m, input logic [7:0] d,
                      input logic [3:0] em, input logic [1:0] eb, input logic ef,
                      input string nm);
    @(posedge clk);
    #1;
    en  = e_n;
    mos = m;
    dt  = d;
    q.push_back('{due: cyc + 1, mos: em, busy: eb, flt: ef, name: nm});
  endtask

  // Expect n cycles of dead time, then the new gate pattern.
  task automatic switch_to(input logic [3:0] m, input logic [7:0] d, input int n, input string nm);
    for (int i = 0; i < n; i++) step(1'b1, m, d, 4'b0000, 2'b11, 1'b0, nm);
    step(1'b1, m, d, m, 2'b00, 1'b0, nm);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_direct(input logic [3:0] em, input logic [1:0] eb, input logic ef,
                              input string nm);
    n_cmp++;
    if ({o_mos, o_busy, o_fault} !== {em, eb, ef}) begin
      n_err++;
      $display("FAIL %s: got mos=%b busy=%b fault=%b, want mos=%b busy=%b fault=%b",
               nm, o_mos, o_busy, o_fault, em, eb, ef);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_direct(4'b0000, 2'b00, 1'b0, "reset_state");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    run_inv = 1'b1;

    // Start-up waits a full dead time of 5
    switch_to(4'b1001, 8'd5, 5, "startup_dt5");
    step(1'b1, 4'b1001, 8'd5, 4'b1001, 2'b00, 1'b0, "steady_1001");

    // Full reversal on both legs
    switch_to(4'b0110, 8'd5, 5, "reverse_0110");
    switch_to(4'b1001, 8'd5, 5, "reverse_1001");

    // Two-cycle glitch to 0110 then back: still a full 5-cycle dead time, never 0110
    step(1'b1, 4'b0110, 8'd5, 4'b0000, 2'b11, 1'b0, "glitch");
    step(1'b1, 4'b0110, 8'd5, 4'b0000, 2'b11, 1'b0, "glitch");
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1001, 8'd5, 4'b0000, 2'b11, 1'b0, "glitch");
    step(1'b1, 4'b1001, 8'd5, 4'b1001, 2'b00, 1'b0, "glitch_restore");

    // Requested 0 clamps to DT_MIN=2
    switch_to(4'b0110, 8'd0, 2, "clamp_dtmin");

    // Dead time changes mid-interval: current interval keeps the loaded 5
    step(1'b1, 4'b1001, 8'd5, 4'b0000, 2'b11, 1'b0, "dt_change");
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1001, 8'd9, 4'b0000, 2'b11, 1'b0, "dt_change");
    step(1'b1, 4'b1001, 8'd9, 4'b1001, 2'b00, 1'b0, "dt_change_done");

    // Disable on the third DT cycle, then re-enable
    step(1'b1, 4'b0110, 8'd5, 4'b0000, 2'b11, 1'b0, "disable_mid_dt");
    step(1'b1, 4'b0110, 8'd5, 4'b0000, 2'b11, 1'b0, "disable_mid_dt");
    step(1'b0, 4'b0110, 8'd5, 4'b0000, 2'b00, 1'b0, "disable_off");
    step(1'b0, 4'b1001, 8'd5, 4'b0000, 2'b00, 1'b0, "disable_hold");
    switch_to(4'b1001, 8'd5, 5, "reenable");

    // Invalid command 0101 (leg A = 11)
    if (FAULT_EN) begin
      step(1'b1, 4'b0101, 8'd5, 4'b0000, 2'b00, 1'b1, "fault_set");
      for (int i = 0; i < 8; i++) step(1'b1, 4'b1001, 8'd5, 4'b0000, 2'b00, 1'b1, "fault_hold");
    end else begin
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0101, 8'd5, 4'b0000, 2'b11, 1'b0, "invalid_as_off");
      step(1'b1, 4'b0101, 8'd5, 4'b0000, 2'b00, 1'b0, "invalid_off");
      step(1'b1, 4'b0101, 8'd5, 4'b0000, 2'b00, 1'b0, "invalid_off_hold");
    end
    drain();

    // Asynchronous reset clears everything, including any fault
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_direct(4'b0000, 2'b00, 1'b0, "async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    switch_to(4'b1001, 8'd3, 3, "after_reset");
    drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
